// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB over a req/ack memory port,
// with illegal-opcode and bus-timeout traps and a retired-instruction counter.
module multicycle_ctrl #(
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 32,
  parameter bit TRAP_EN     = 1'b1
) (
  input  logic             clk_w_i,
  input  logic             rst_w_i_l,
  input  logic [6:0]       opcode_w_i,
  input  logic             cmp_true_w_i_h,
  input  logic             mem_ack_w_i_h,
  input  logic             trap_clr_w_i_h,
  output logic             mem_req_w_o_h,
  output logic             mem_we_w_o_h,
  output logic             ir_wr_w_o_h,
  output logic             pc_wr_w_o_h,
  output logic             reg_write_w_o_h,
  output logic             alu_src_a_w_o,
  output logic             alu_src_b_w_o,
  output logic             mem_to_reg_w_o_h,
  output logic             imm_to_reg_w_o_h,
  output logic             pc_to_reg_w_o,
  output logic             trap_w_o_h,
  output logic [1:0]       trap_cause_w_o,
  output logic [2:0]       state_w_o,
  output logic [CNT_W-1:0] instr_cnt_w_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  state_t           state_q, state_nxt;
  logic [1:0]       cause_q, cause_nxt;
  logic [TO_W-1:0]  to_cnt_q;
  logic [CNT_W-1:0] instr_cnt_q;

  logic is_jal, is_jalr, is_lui, is_auipc, is_branch;
  logic is_store, is_load, is_opimm, is_op, is_legal;

  assign is_jal    = (opcode_w_i == 7'b1101111);
  assign is_jalr   = (opcode_w_i == 7'b1100111);
  assign is_lui    = (opcode_w_i == 7'b0110111);
  assign is_auipc  = (opcode_w_i == 7'b0010111);
  assign is_branch = (opcode_w_i == 7'b1100011);
  assign is_store  = (opcode_w_i == 7'b0100011);
  assign is_load   = (opcode_w_i == 7'b0000011);
  assign is_opimm  = (opcode_w_i == 7'b0010011);
  assign is_op     = (opcode_w_i == 7'b0110011);
  assign is_legal  = is_jal | is_jalr | is_lui | is_auipc | is_branch |
                     is_store | is_load | is_opimm | is_op;

  // Strobes are Mealy outputs of the registered state; IDLE (the reset state) drives none,
  // so an asserted reset zeroes every strobe without waiting for a clock.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_nxt        = state_q;
    cause_nxt        = cause_q;
    mem_req_w_o_h    = 1'b0;
    mem_we_w_o_h     = 1'b0;
    ir_wr_w_o_h      = 1'b0;
    pc_wr_w_o_h      = 1'b0;
    reg_write_w_o_h  = 1'b0;
    alu_src_a_w_o    = 1'b0;
    alu_src_b_w_o    = 1'b0;
    mem_to_reg_w_o_h = 1'b0;
    imm_to_reg_w_o_h = 1'b0;
    pc_to_reg_w_o    = 1'b0;

    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      alu_src_a_w_o = is_jal | is_jalr | is_auipc | is_branch;
      alu_src_b_w_o = is_jal | is_jalr | is_auipc | is_branch |
                      is_store | is_load | is_opimm;
    end

    unique case (state_q)
      S_IDLE:  state_nxt = S_FETCH;
      S_FETCH: begin
        mem_req_w_o_h = 1'b1;
        if (mem_ack_w_i_h) begin
          ir_wr_w_o_h = 1'b1;
          pc_wr_w_o_h = 1'b1;
          state_nxt   = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_legal) begin
          state_nxt = S_EXEC;
        end else if (TRAP_EN) begin
          state_nxt = S_TRAP;
          cause_nxt = CAUSE_ILLEGAL;
        end else begin
          state_nxt = S_FETCH;
        end
      end
      S_EXEC: begin
        state_nxt = S_FETCH;
        if (is_jal || is_jalr) begin
          reg_write_w_o_h = 1'b1;
          pc_to_reg_w_o   = 1'b1;
          pc_wr_w_o_h     = 1'b1;
        end else if (is_branch) begin
          pc_wr_w_o_h = cmp_true_w_i_h;
        end else if (is_lui) begin
          reg_write_w_o_h  = 1'b1;
          imm_to_reg_w_o_h = 1'b1;
        end else if (is_auipc || is_op || is_opimm) begin
          reg_write_w_o_h = 1'b1;
        end else if (is_load || is_store) begin
          state_nxt = S_MEM;
        end
      end
      S_MEM: begin
        mem_req_w_o_h = 1'b1;
        mem_we_w_o_h  = is_store;
        if (mem_ack_w_i_h) state_nxt = is_load ? S_WB : S_FETCH;
      end
      S_WB: begin
        reg_write_w_o_h  = 1'b1;
        mem_to_reg_w_o_h = 1'b1;
        state_nxt        = S_FETCH;
      end
      S_TRAP: begin
        if (trap_clr_w_i_h) begin
          state_nxt = S_FETCH;
          cause_nxt = CAUSE_NONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // An ack in the last allowed cycle completes the request instead of trapping.
    if (TRAP_EN && mem_req_w_o_h && !mem_ack_w_i_h && to_cnt_q == TO_LAST) begin
      state_nxt = S_TRAP;
      cause_nxt = CAUSE_TIMEOUT;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_w_i or negedge rst_w_i_l) begin
    if (!rst_w_i_l) begin
      state_q     <= S_IDLE;
      cause_q     <= CAUSE_NONE;
      to_cnt_q    <= '0;
      instr_cnt_q <= '0;
    end else begin
      state_q <= state_nxt;
      cause_q <= cause_nxt;

      // Any state change (entry to FETCH/MEM included) or an ack restarts the wait count.
      if (state_nxt != state_q || mem_ack_w_i_h) to_cnt_q <= '0;
      else if (mem_req_w_o_h)                    to_cnt_q <= to_cnt_q + TO_W'(1);

      if (state_nxt == S_FETCH &&
          (state_q == S_DECODE || state_q == S_EXEC || state_q == S_MEM || state_q == S_WB))
        instr_cnt_q <= instr_cnt_q + CNT_W'(1);
    end
  end

  assign trap_w_o_h     = (state_q == S_TRAP);
  assign trap_cause_w_o = cause_q;
  assign state_w_o      = state_q;
  assign instr_cnt_w_o  = instr_cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the stimulus queues one expected output vector per
// cycle, and a monitor compares it against the DUT on the falling edge.
module tb_multicycle_ctrl;

  localparam logic [10:0] NONE = 11'h000;
  localparam logic [10:0] REQ  = 11'h400;
  localparam logic [10:0] WE   = 11'h200;
  localparam logic [10:0] IRW  = 11'h100;
  localparam logic [10:0] PCW  = 11'h080;
  localparam logic [10:0] RW   = 11'h040;
  localparam logic [10:0] AA   = 11'h020;
  localparam logic [10:0] AB   = 11'h010;
  localparam logic [10:0] M2R  = 11'h008;
  localparam logic [10:0] I2R  = 11'h004;
  localparam logic [10:0] P2R  = 11'h002;
  localparam logic [10:0] TRP  = 11'h001;

  localparam logic [6:0] OP_ADDI  = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_BAD   = 7'b0000000;

  typedef struct {
    logic        b_sel;
    logic [2:0]  st;
    logic [10:0] strb;
    logic [1:0]  cause;
    logic [31:0] cnt;
    string       name;
  } exp_t;

  exp_t q[$];

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  logic [6:0] op = '0;
  logic ack = 1'b0, cmp = 1'b0, clr = 1'b0;
  logic b_sel = 1'b0;
  logic done = 1'b0;
  int checks = 0;
  int errors = 0;

  logic req_a, we_a, irw_a, pcw_a, rw_a, aa_a, ab_a, m2r_a, i2r_a, p2r_a, trap_a;
  logic [1:0] cause_a;
  logic [2:0] st_a;
  logic [31:0] cnt_a;
  logic req_b, we_b, irw_b, pcw_b, rw_b, aa_b, ab_b, m2r_b, i2r_b, p2r_b, trap_b;
  logic [1:0] cause_b;
  logic [2:0] st_b;
  logic [31:0] cnt_b;

  always #5 clk = ~clk;

  multicycle_ctrl #(.TIMEOUT_CYC(16), .CNT_W(32), .TRAP_EN(1'b1)) dut_a (
    .clk_w_i(clk), .rst_w_i_l(rst_a), .opcode_w_i(op), .cmp_true_w_i_h(cmp),
    .mem_ack_w_i_h(ack), .trap_clr_w_i_h(clr),
    .mem_req_w_o_h(req_a), .mem_we_w_o_h(we_a), .ir_wr_w_o_h(irw_a), .pc_wr_w_o_h(pcw_a),
    .reg_write_w_o_h(rw_a), .alu_src_a_w_o(aa_a), .alu_src_b_w_o(ab_a),
    .mem_to_reg_w_o_h(m2r_a), .imm_to_reg_w_o_h(i2r_a), .pc_to_reg_w_o(p2r_a),
    .trap_w_o_h(trap_a), .trap_cause_w_o(cause_a), .state_w_o(st_a), .instr_cnt_w_o(cnt_a)
  );

  multicycle_ctrl #(.TIMEOUT_CYC(16), .CNT_W(32), .TRAP_EN(1'b0)) dut_b (
    .clk_w_i(clk), .rst_w_i_l(rst_b), .opcode_w_i(op), .cmp_true_w_i_h(cmp),
    .mem_ack_w_i_h(ack), .trap_clr_w_i_h(clr),
    .mem_req_w_o_h(req_b), .mem_we_w_o_h(we_b), .ir_wr_w_o_h(irw_b), .pc_wr_w_o_h(pcw_b),
    .reg_write_w_o_h(rw_b), .alu_src_a_w_o(aa_b), .alu_src_b_w_o(ab_b),
    .mem_to_reg_w_o_h(m2r_b), .imm_to_reg_w_o_h(i2r_b), .pc_to_reg_w_o(p2r_b),
    .trap_w_o_h(trap_b), .trap_cause_w_o(cause_b), .state_w_o(st_b), .instr_cnt_w_o(cnt_b)
  );

  task automatic check(input logic ok, input string name);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL %s", name);
    end
  endtask

  // Drive one cycle's inputs, queue the outputs expected during that cycle, advance a clock.
  task automatic cyc(input logic [6:0] i_op, input logic i_ack, input logic i_cmp,
                     input logic i_clr, input logic [2:0] e_st, input logic [10:0] e_strb,
                     input logic [1:0] e_cause, input int e_cnt, input string name);
    exp_t e;
    op  = i_op;
    ack = i_ack;
    cmp = i_cmp;
    clr = i_clr;
    e.b_sel = b_sel;
    e.st    = e_st;
    e.strb  = e_strb;
    e.cause = e_cause;
    e.cnt   = e_cnt;
    e.name  = name;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares the oldest queued vector against the selected DUT on each falling edge.
  initial begin : monitor
    exp_t e;
    logic [10:0] a_strb;
    logic [2:0]  a_st;
    logic [1:0]  a_cause;
    logic [31:0] a_cnt;
    logic        ok;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.b_sel) begin
          a_strb  = {req_b, we_b, irw_b, pcw_b, rw_b, aa_b, ab_b, m2r_b, i2r_b, p2r_b, trap_b};
          a_st    = st_b;
          a_cause = cause_b;
          a_cnt   = cnt_b;
        end else begin
          a_strb  = {req_a, we_a, irw_a, pcw_a, rw_a, aa_a, ab_a, m2r_a, i2r_a, p2r_a, trap_a};
          a_st    = st_a;
          a_cause = cause_a;
          a_cnt   = cnt_a;
        end
        ok = (a_st === e.st && a_strb === e.strb && a_cause === e.cause && a_cnt === e.cnt);
        if (!ok)
          $display("  got state %0d strobes %h cause %0d cnt %0d, want state %0d strobes %h cause %0d cnt %0d",
                   a_st, a_strb, a_cause, a_cnt, e.st, e.strb, e.cause, e.cnt);
        check(ok, e.name);
      end else if (done) begin
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  initial begin : stimulus
    @(posedge clk);
    #1;
    check(st_a === 3'd0 && cause_a === 2'b00 && cnt_a === 32'd0 &&
          {req_a, we_a, irw_a, pcw_a, rw_a, aa_a, ab_a, m2r_a, i2r_a, p2r_a, trap_a} === NONE,
          "reset_state");
    cyc(OP_ADDI, 1'b1, 1'b0, 1'b0, 3'd0, NONE, 2'b00, 0, "in_reset");
    rst_a = 1'b1;
    cyc(OP_ADDI, 1'b0, 1'b0, 1'b0, 3'd0, NONE, 2'b00, 0, "idle");

    // ADDI, zero-wait fetch
    cyc(OP_ADDI, 1'b1, 1'b0, 1'b0, 3'd1, REQ | IRW | PCW, 2'b00, 0, "addi_fetch");
    cyc(OP_ADDI, 1'b0, 1'b0, 1'b0, 3'd2, NONE, 2'b00, 0, "addi_decode");
    cyc(OP_ADDI, 1'b0, 1'b0, 1'b0, 3'd3, RW | AB, 2'b00, 0, "addi_exec");

    // LOAD with two wait cycles in MEM
    cyc(OP_LOAD, 1'b1, 1'b0, 1'b0, 3'd1, REQ | IRW | PCW, 2'b00, 1, "load_fetch");
    cyc(OP_LOAD, 1'b0, 1'b0, 1'b0, 3'd2, NONE, 2'b00, 1, "load_decode");
    cyc(OP_LOAD, 1'b0, 1'b0, 1'b0, 3'd3, AB, 2'b00, 1, "load_exec");
    cyc(OP_LOAD, 1'b0, 1'b0, 1'b0, 3'd4, REQ | AB, 2'b00, 1, "load_mem_w1");
    cyc(OP_LOAD, 1'b0, 1'b0, 1'b0, 3'd4, REQ | AB, 2'b00, 1, "load_mem_w2");
    cyc(OP_LOAD, 1'b1, 1'b0, 1'b0, 3'd4, REQ | AB, 2'b00, 1, "load_mem_ack");
    cyc(OP_LOAD, 1'b0, 1'b0, 1'b0, 3'd5, RW | M2R | AB, 2'b00, 1, "load_wb");

    // BEQ not taken, then taken
    cyc(OP_BEQ, 1'b1, 1'b0, 1'b0, 3'd1, REQ | IRW | PCW, 2'b00, 2, "beq0_fetch");
    cyc(OP_BEQ, 1'b0, 1'b0, 1'b0, 3'd2, NONE, 2'b00, 2, "beq0_decode");
    cyc(OP_BEQ, 1'b0, 1'b0, 1'b0, 3'd3, AA | AB, 2'b00, 2, "beq0_exec");
    cyc(OP_BEQ, 1'b1, 1'b1, 1'b0, 3'd1, REQ | IRW | PCW, 2'b00, 3, "beq1_fetch");
    cyc(OP_BEQ, 1'b0, 1'b1, 1'b0, 3'd2, NONE, 2'b00, 3, "beq1_decode");
    cyc(OP_BEQ, 1'b0, 1'b1, 1'b0, 3'd3, AA | AB | PCW, 2'b00, 3, "beq1_exec");

    // JAL and LUI
    cyc(OP_JAL, 1'b1, 1'b0, 1'b0, 3'd1, REQ | IRW | PCW, 2'b00, 4, "jal_fetch");
    cyc(OP_JAL, 1'b0, 1'b0, 1'b0, 3'd2, NONE, 2'b00, 4, "jal_decode");
    cyc(OP_JAL, 1'b0, 1'b0, 1'b0, 3'd3, RW | P2R | PCW | AA | AB, 2'b00, 4, "jal_exec");
    cyc(OP_LUI, 1'b1, 1'b0, 1'b0, 3'd1, REQ | IRW | PCW, 2'b00, 5, "lui_fetch");
    cyc(OP_LUI, 1'b0, 1'b0, 1'b0, 3'd2, NONE, 2'b00, 5, "lui_decode");
    cyc(OP_LUI, 1'b0, 1'b0, 1'b0, 3'd3, RW | I2R, 2'b00, 5, "lui_exec");

    // STORE, zero wait: four cycles
    cyc(OP_STORE, 1'b1, 1'b0, 1'b0, 3'd1, REQ | IRW | PCW, 2'b00, 6, "st_fetch");
    cyc(OP_STORE, 1'b0, 1'b0, 1'b0, 3'd2, NONE, 2'b00, 6, "st_decode");
    cyc(OP_STORE, 1'b0, 1'b0, 1'b0, 3'd3, AB, 2'b00, 6, "st_exec");
    cyc(OP_STORE, 1'b1, 1'b0, 1'b0, 3'd4, REQ | WE | AB, 2'b00, 6, "st_mem");

    // Illegal opcode trap, held, then cleared
    cyc(OP_BAD, 1'b1, 1'b0, 1'b0, 3'd1, REQ | IRW | PCW, 2'b00, 7, "ill_fetch");
    cyc(OP_BAD, 1'b0, 1'b0, 1'b0, 3'd2, NONE, 2'b00, 7, "ill_decode");
    cyc(OP_BAD, 1'b1, 1'b0, 1'b0, 3'd6, TRP, 2'b01, 7, "ill_trap_hold");
    cyc(OP_BAD, 1'b0, 1'b0, 1'b1, 3'd6, TRP, 2'b01, 7, "ill_trap_clr");

    // Fetch timeout after 16 unacked request cycles
    for (int i = 0; i < 16; i++)
      cyc(OP_ADDI, 1'b0, 1'b0, 1'b0, 3'd1, REQ, 2'b00, 7, "to_fetch_wait");
    check(st_a === 3'd6 && trap_a === 1'b1 && cause_a === 2'b10 && req_a === 1'b0,
          "timeout_expired");
    cyc(OP_ADDI, 1'b0, 1'b0, 1'b0, 3'd6, TRP, 2'b10, 7, "to_trap");
    cyc(OP_ADDI, 1'b0, 1'b0, 1'b1, 3'd6, TRP, 2'b10, 7, "to_trap_clr");

    // Ack on the 16th request cycle wins over the timeout
    for (int i = 0; i < 15; i++)
      cyc(OP_ADDI, 1'b0, 1'b0, 1'b0, 3'd1, REQ, 2'b00, 7, "late_fetch_wait");
    cyc(OP_ADDI, 1'b1, 1'b0, 1'b0, 3'd1, REQ | IRW | PCW, 2'b00, 7, "late_fetch_ack");
    cyc(OP_ADDI, 1'b0, 1'b0, 1'b0, 3'd2, NONE, 2'b00, 7, "late_decode");
    cyc(OP_ADDI, 1'b0, 1'b0, 1'b0, 3'd3, RW | AB, 2'b00, 7, "late_exec");

    // STORE interrupted by reset while waiting in MEM
    cyc(OP_STORE, 1'b1, 1'b0, 1'b0, 3'd1, REQ | IRW | PCW, 2'b00, 8, "rst_st_fetch");
    cyc(OP_STORE, 1'b0, 1'b0, 1'b0, 3'd2, NONE, 2'b00, 8, "rst_st_decode");
    cyc(OP_STORE, 1'b0, 1'b0, 1'b0, 3'd3, AB, 2'b00, 8, "rst_st_exec");
    cyc(OP_STORE, 1'b0, 1'b0, 1'b0, 3'd4, REQ | WE | AB, 2'b00, 8, "rst_st_mem");
    rst_a = 1'b0;
    cyc(OP_STORE, 1'b1, 1'b0, 1'b0, 3'd0, NONE, 2'b00, 0, "rst_async_zero");
    cyc(OP_STORE, 1'b1, 1'b0, 1'b0, 3'd0, NONE, 2'b00, 0, "rst_held");
    rst_a = 1'b1;
    cyc(OP_ADDI, 1'b0, 1'b0, 1'b0, 3'd0, NONE, 2'b00, 0, "rst_idle");
    cyc(OP_ADDI, 1'b0, 1'b0, 1'b0, 3'd1, REQ, 2'b00, 0, "rst_fetch");

    // TRAP_EN=0: illegal opcode retires as NOP, timeout disabled, trap_clr ignored
    b_sel = 1'b1;
    rst_b = 1'b1;
    cyc(OP_BAD, 1'b0, 1'b0, 1'b0, 3'd0, NONE, 2'b00, 0, "nt_idle");
    cyc(OP_BAD, 1'b1, 1'b0, 1'b0, 3'd1, REQ | IRW | PCW, 2'b00, 0, "nt_fetch");
    cyc(OP_BAD, 1'b0, 1'b0, 1'b0, 3'd2, NONE, 2'b00, 0, "nt_decode");
    for (int i = 0; i < 20; i++)
      cyc(OP_BAD, 1'b0, 1'b0, 1'b0, 3'd1, REQ, 2'b00, 1, "nt_fetch_wait");
    cyc(OP_BAD, 1'b0, 1'b0, 1'b1, 3'd1, REQ, 2'b00, 1, "nt_clr_ignored");
    cyc(OP_BAD, 1'b0, 1'b0, 1'b0, 3'd1, REQ, 2'b00, 1, "nt_still_fetch");

    done = 1'b1;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Parametrised multi-cycle control sequencer for the CPE RV32I core. It replaces the single-cycle opcode decoder with an FSM that steps each instruction through FETCH/DECODE/EXEC/MEM/WB. It talks to a shared instruction/data memory over a req/ack handshake. It adds illegal-opcode and bus-timeout traps plus a retired-instruction counter, and sits between the IR/PC registers, the ALU muxes, the register file and the memory port.

Parameters:
TIMEOUT_CYC, 16, cycles mem_req may stay unacked before a bus-timeout trap (min 2)
CNT_W, 32, width of retired-instruction counter
TRAP_EN, 1, 1 = traps enabled; 0 = illegal opcodes retire as NOP and timeouts are disabled

Ports:
clk_w_i  in  1  clock, rising edge
rst_w_i_l  in  1  asynchronous active-low reset
opcode_w_i  in  7  opcode from IR; valid from DECODE onward
cmp_true_w_i_h  in  1  branch comparator result, sampled in EXEC
mem_ack_w_i_h  in  1  memory completes current request this cycle
trap_clr_w_i_h  in  1  leave TRAP
mem_req_w_o_h  out  1  memory request
mem_we_w_o_h  out  1  request is a write
ir_wr_w_o_h  out  1  load IR from memory data
pc_wr_w_o_h  out  1  PC update strobe
reg_write_w_o_h  out  1  register-file write strobe
alu_src_a_w_o  out  1  ALU A select (1 = PC)
alu_src_b_w_o  out  1  ALU B select (1 = imm)
mem_to_reg_w_o_h  out  1  writeback selects load data
imm_to_reg_w_o_h  out  1  writeback selects immediate (LUI)
pc_to_reg_w_o  out  1  writeback selects PC+4 (JAL/JALR)
trap_w_o_h  out  1  core halted in TRAP
trap_cause_w_o  out  2  00 none, 01 illegal opcode, 10 bus timeout
state_w_o  out  3  current state encoding
instr_cnt_w_o  out  CNT_W  retired-instruction count

Behaviour:
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- Reset: state=IDLE, timeout counter=0, instr_cnt=0, trap_cause=00. All outputs read 0 while reset is low, and drop to 0 immediately when reset asserts mid-operation.
- IDLE: all strobes 0. Moves to FETCH on the first clock after reset release.
- Outputs are combinational from the registered state, opcode_w_i, mem_ack and cmp_true. Every strobe not listed for a state is 0.
- FETCH: mem_req=1, mem_we=0.
  - On ack: ir_wr=1 and pc_wr=1 in that same cycle, then go to DECODE.
- DECODE: no strobes.
  - Legal opcodes are 1101111, 0110111, 0010111, 1100011, 0100011, 1100111, 0000011, 0010011 and 0110011.
  - Legal opcode: go to EXEC.
  - Illegal opcode with TRAP_EN=1: go to TRAP, cause=01.
  - Illegal opcode with TRAP_EN=0: go to FETCH and count as retired.
- ALU source selects (a/b), driven in EXEC, MEM and WB:
  - JAL 1/1, JALR 1/1, LUI 0/0, AUIPC 1/1, BRANCH 1/1
  - STORE 0/1, LOAD 0/1, OP-IMM 0/1, OP 0/0
  - Outside EXEC, MEM and WB both selects are 0.
- EXEC actions:
  - JAL/JALR: reg_write=1, pc_to_reg=1, pc_wr=1; go to FETCH.
  - BRANCH: pc_wr=cmp_true; go to FETCH.
  - LUI: reg_write=1, imm_to_reg=1; go to FETCH.
  - AUIPC/OP/OP-IMM: reg_write=1; go to FETCH.
  - LOAD/STORE: go to MEM.
- MEM: mem_req=1, mem_we=1 for STORE and 0 for LOAD.
  - On ack: STORE goes to FETCH, LOAD goes to WB.
- WB: reg_write=1, mem_to_reg=1; go to FETCH.
- Timeout:
  - Counter clears on entry to FETCH or MEM and on ack.
  - It increments every cycle mem_req=1 with no ack.
  - If the counter equals TIMEOUT_CYC-1 and there is no ack, go to TRAP with cause=10.
  - An ack in that same cycle wins: no trap.
  - Not active when TRAP_EN=0; the FSM waits indefinitely.
- TRAP: all strobes 0, trap_w_o_h=1, cause held.
  - On trap_clr: go to FETCH and clear cause to 00.
  - trap_clr is ignored in every other state.
- instr_cnt increments by 1 on every transition into FETCH from DECODE, EXEC, MEM or WB. It wraps at 2^CNT_W. TRAP->FETCH does not count.
- Latency with zero-wait memory (ack in the first request cycle):
  - ALU/branch/jump/LUI: 3 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.

Test Plan:
- Reset release, ADDI (0010011), ack in first FETCH cycle -> state 0,1,2,3,1. reg_write=1 and alu_src_b=1 for exactly the EXEC cycle. instr_cnt 0->1.
- LOAD (0000011), ack 2 cycles late in MEM -> mem_req high for 3 MEM cycles with mem_we=0. WB has reg_write=1 and mem_to_reg=1. instr_cnt +1.
- BEQ twice, cmp_true=0 then 1 -> pc_wr in EXEC is 0 then 1. reg_write stays 0 throughout.
- Opcode 0000000 -> TRAP after DECODE with trap_w_o_h=1, cause=01, instr_cnt unchanged. trap_clr pulse -> FETCH with cause=00. Repeat with TRAP_EN=0 -> FETCH with instr_cnt +1.
- FETCH with no ack, TIMEOUT_CYC=16 -> TRAP cause=10 after 16 request cycles. A repeat run with ack on the 16th cycle -> no trap, DECODE next.
- rst_w_i_l low mid-MEM (STORE) -> all outputs 0 asynchronously. After release: IDLE, then FETCH, with instr_cnt=0.
